ahb2apb_multi_bridge: RTL and testbench

//  Parametrised AHB-Lite slave to APB4 master bridge driving NUM_SLV APB slaves.
//  - Decodes a region index from haddr and drives a one-hot psel.
//  - Returns prdata on hrdata and generates pstrb from hsize and haddr.
//  - Converts pslverr, unmapped addresses and illegal hsize into a two-cycle AHB ERROR.
//  - Sits between the AHB interconnect slave port and the APB peripheral cluster.

---
 rtl/ahb_apb_pkg.sv | 33 +++
 rtl/ahb2apb_multi_bridge_if.sv | 42 ++++
 rtl/apb_region_decode.sv | 24 ++
 rtl/ahb2apb_multi_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_ahb2apb_multi_bridge.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB4 multi-slave bridge: transfer types,
// response codes, bridge FSM states and a constant-foldable clog2.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb2apb_multi_bridge_if.sv
// Bus bundle for the bridge: AHB-Lite slave-side signals plus the APB4 cluster.
// The slave modport is the bridge's view; master is the interconnect/peripheral side.
interface ahb2apb_multi_bridge_if #(
    parameter int HADDR_WIDTH = 32,
    parameter int PADDR_WIDTH = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLV     = 4
);
    logic                          hsel;
    logic [HADDR_WIDTH-1:0]        haddr;
    logic [1:0]                    htrans;
    logic                          hwrite;
    logic [2:0]                    hsize;
    logic [DATA_WIDTH-1:0]         hwdata;
    logic                          hready;
    logic                          hreadyout;
    logic                          hresp;
    logic [DATA_WIDTH-1:0]         hrdata;
    logic [NUM_SLV-1:0]            psel;
    logic                          penable;
    logic [PADDR_WIDTH-1:0]        paddr;
    logic                          pwrite;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [DATA_WIDTH/8-1:0]       pstrb;
    logic [NUM_SLV*DATA_WIDTH-1:0] prdata;
    logic [NUM_SLV-1:0]            pready;
    logic [NUM_SLV-1:0]            pslverr;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata,
        output psel, penable, paddr, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata,
        input  psel, penable, paddr, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_region_decode.sv
// Combinational region decode: slave index from the haddr select field, and the
// illegal flag for unmapped regions or transfer sizes wider than the data bus.
module apb_region_decode
    import ahb_apb_pkg::*;
#(
    parameter int HADDR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_SEL_LSB = 12,
    parameter int SEL_W       = 2
) (
    input  logic [HADDR_WIDTH-1:0] haddr,
    input  logic [2:0]             hsize,
    output logic [SEL_W-1:0]       index,
    output logic                   illegal
);
    localparam int SIZE_MAX = clog2(DATA_WIDTH / 8);

    logic unused_haddr;
    assign unused_haddr = ^haddr;

    assign index   = haddr[SLV_SEL_LSB +: SEL_W];
    assign illegal = (int'(index) >= NUM_SLV) || (int'(hsize) > SIZE_MAX);
endmodule

// File: rtl/ahb2apb_multi_bridge.sv
// AHB-Lite slave to APB4 master bridge fanning out to NUM_SLV one-hot selected slaves.
// Optional build macro APB_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES.
module ahb2apb_multi_bridge
    import ahb_apb_pkg::*;
#(
    parameter int HADDR_WIDTH    = 32,
    parameter int PADDR_WIDTH    = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLV        = 4,
    parameter int SLV_SEL_LSB    = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                   hclk,
    input logic                   hreset,
    ahb2apb_multi_bridge_if.slave bus
);
    localparam int SEL_W  = (NUM_SLV > 1) ? clog2(NUM_SLV) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = clog2(STRB_W);

    state_e                  state_q, state_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic [NUM_SLV-1:0]      psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic [SEL_W-1:0]        index_q, index_d;

    logic                    accept;
    logic [SEL_W-1:0]        dec_index;
    logic                    dec_illegal;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    unused_htrans;

`ifdef APB_TIMEOUT_EN
    localparam int                CNT_W    = clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    function automatic logic [NUM_SLV-1:0] slv_onehot(input logic [SEL_W-1:0] idx);
        return NUM_SLV'(1) << idx;
    endfunction

    // Byte lanes covered by the transfer, with the start lane aligned down to the size.
    function automatic logic [STRB_W-1:0] lane_mask(input logic [LANE_W-1:0] lsb,
                                                    input logic [2:0]        size);
        logic [STRB_W-1:0] mask;
        int                bytes;
        int                base;
        bytes = 1 << size;
        base  = int'(lsb) & ~(bytes - 1);
        mask  = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if (i >= base && i < base + bytes) mask[i] = 1'b1;
        end
        return mask;
    endfunction

    apb_region_decode #(
        .HADDR_WIDTH (HADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_SLV     (NUM_SLV),
        .SLV_SEL_LSB (SLV_SEL_LSB),
        .SEL_W       (SEL_W)
    ) u_decode (
        .haddr   (bus.haddr),
        .hsize   (bus.hsize),
        .index   (dec_index),
        .illegal (dec_illegal)
    );

    assign accept        = bus.hsel & bus.hready & bus.htrans[1];
    assign unused_htrans = bus.htrans[0];

    // The registered one-hot psel doubles as the response mux select.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                sel_ready = bus.pready[i];
                sel_err   = bus.pslverr[i];
                sel_rdata = bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        index_d     = index_q;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_WDATA: begin
                pwdata_d = bus.hwdata;
                psel_d   = slv_onehot(index_q);
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (sel_err) begin
                        state_d = ST_ERR1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d     = ST_IDLE;
                        hreadyout_d = 1'b1;
                        if (!pwrite_q) hrdata_d = sel_rdata;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_ERR1;
                    hresp_d   = HRESP_ERROR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_ERR1: begin
                hreadyout_d = 1'b1;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_d = HRESP_OKAY;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance in IDLE or the second error cycle overrides the default exit.
        if (accept && (state_q == ST_IDLE || state_q == ST_ERR2)) begin
            index_d     = dec_index;
            paddr_d     = bus.haddr[PADDR_WIDTH-1:0];
            pwrite_d    = bus.hwrite;
            pstrb_d     = bus.hwrite ? lane_mask(bus.haddr[LANE_W-1:0], bus.hsize) : '0;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_OKAY;
            if (dec_illegal) begin
                state_d = ST_ERR1;
                hresp_d = HRESP_ERROR;
            end else if (bus.hwrite) begin
                state_d = ST_WDATA;
            end else begin
                state_d = ST_SETUP;
                psel_d  = slv_onehot(dec_index);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            index_q     <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            index_q     <= index_d;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
endmodule

// File: tb/tb_ahb2apb_multi_bridge.sv
// Directed bench for ahb2apb_multi_bridge: a 4-slave instance for the main traffic
// and a 3-slave instance for the unmapped-region decode.
module tb_ahb2apb_multi_bridge;
    import ahb_apb_pkg::*;

    localparam int XFER_LIMIT = 600;

    logic hclk;
    logic hreset;
    int   n_total;
    int   n_bad;
    int   cyc;

    logic [3:0]  obs_psel, any_psel, err_psel, obs_pstrb;
    logic [15:0] obs_paddr;
    logic [31:0] obs_pwdata;
    logic        obs_pwrite;
    int          hresp_cnt;
    int          waits, waits_r, c0, c1;

    ahb2apb_multi_bridge_if #(.HADDR_WIDTH(32), .PADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLV(4)) bus ();
    ahb2apb_multi_bridge_if #(.HADDR_WIDTH(32), .PADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLV(3)) bus3 ();

    ahb2apb_multi_bridge #(
        .HADDR_WIDTH(32), .PADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLV(4),
        .SLV_SEL_LSB(12), .TIMEOUT_CYCLES(256)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    ahb2apb_multi_bridge #(
        .HADDR_WIDTH(32), .PADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLV(3),
        .SLV_SEL_LSB(12), .TIMEOUT_CYCLES(256)
    ) dut3 (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus3)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
        cyc++;
    endtask

    task automatic bus_idle();
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
    endtask

    // Presents one transfer, then plays the selected APB slave: not ready for
    // low_cycles ACCESS cycles, then ready with pslverr=err. Unselected slaves
    // present the opposite ready/error levels, which must be ignored.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [31:0] wdata, input int low_cycles, input logic err,
                           output int nwait);
        int acc;
        nwait = 0;
        acc   = 0;
        obs_psel = '0; any_psel = '0; err_psel = '0; obs_pstrb = '0;
        obs_paddr = '0; obs_pwdata = '0; obs_pwrite = 1'b0; hresp_cnt = 0;
        bus.hsel   = 1'b1;
        bus.haddr  = addr;
        bus.htrans = HTRANS_NONSEQ;
        bus.hwrite = wr;
        bus.hsize  = size;
        tick();
        bus_idle();
        bus.hwdata = wdata;
        while (bus.hreadyout == 1'b0 && nwait < XFER_LIMIT) begin
            nwait++;
            any_psel |= bus.psel;
            if (bus.hresp) begin
                hresp_cnt++;
                err_psel |= bus.psel;
            end
            if (bus.psel != '0 && !bus.penable) begin
                obs_psel   = bus.psel;
                obs_paddr  = bus.paddr;
                obs_pstrb  = bus.pstrb;
                obs_pwdata = bus.pwdata;
                obs_pwrite = bus.pwrite;
            end
            if (bus.penable) acc++;
            bus.pready  = (acc > low_cycles) ? 4'hF : ~bus.psel;
            bus.pslverr = err ? bus.psel : ~bus.psel;
            tick();
        end
        chk("xfer_done", bus.hreadyout, 1'b1);
    endtask

    initial begin
        n_total = 0; n_bad = 0; cyc = 0;
        hreset = 1'b1;
        bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.hwdata = '0; bus.hready = 1'b1;
        bus.pready = 4'hF; bus.pslverr = '0;
        bus.prdata = {32'h33333333, 32'h12345678, 32'hAAAAAAAA, 32'hCAFEF00D};
        bus3.hsel = 1'b0; bus3.haddr = '0; bus3.htrans = HTRANS_IDLE; bus3.hwrite = 1'b0;
        bus3.hsize = 3'd0; bus3.hwdata = '0; bus3.hready = 1'b1;
        bus3.pready = 3'b111; bus3.pslverr = '0; bus3.prdata = '0;
        tick();
        tick();
        chk("rst_hreadyout", bus.hreadyout, 1'b1);
        chk("rst_hresp",     bus.hresp,     1'b0);
        chk("rst_hrdata",    bus.hrdata,    32'h0);
        chk("rst_psel",      bus.psel,      4'h0);
        chk("rst_penable",   bus.penable,   1'b0);
        chk("rst_paddr",     bus.paddr,     16'h0);
        chk("rst_pwrite",    bus.pwrite,    1'b0);
        chk("rst_pwdata",    bus.pwdata,    32'h0);
        chk("rst_pstrb",     bus.pstrb,     4'h0);
        hreset = 1'b0;
        tick();

        // Word write to slave 1
        do_xfer(32'h0000_1004, 1'b1, 3'd2, 32'hDEADBEEF, 0, 1'b0, waits);
        chk("wr_waits",  waits,      3);
        chk("wr_psel",   obs_psel,   4'b0010);
        chk("wr_paddr",  obs_paddr,  16'h1004);
        chk("wr_pstrb",  obs_pstrb,  4'hF);
        chk("wr_pwdata", obs_pwdata, 32'hDEADBEEF);
        chk("wr_pwrite", obs_pwrite, 1'b1);
        chk("wr_hresp",  bus.hresp,  1'b0);
        chk("wr_psel_done", bus.psel, 4'h0);

        // Read from slave 2 with two not-ready ACCESS cycles
        do_xfer(32'h0000_2008, 1'b0, 3'd2, 32'h0, 2, 1'b0, waits);
        chk("rd_waits",  waits,      4);
        chk("rd_psel",   obs_psel,   4'b0100);
        chk("rd_paddr",  obs_paddr,  16'h2008);
        chk("rd_pstrb",  obs_pstrb,  4'h0);
        chk("rd_hrdata", bus.hrdata, 32'h12345678);
        chk("rd_hresp",  bus.hresp,  1'b0);

        // Sub-word strobes
        do_xfer(32'h0000_0003, 1'b1, 3'd0, 32'h0, 0, 1'b0, waits);
        chk("byte3_pstrb", obs_pstrb, 4'b1000);
        chk("byte3_psel",  obs_psel,  4'b0001);
        do_xfer(32'h0000_0002, 1'b1, 3'd1, 32'h0, 0, 1'b0, waits);
        chk("half2_pstrb", obs_pstrb, 4'b1100);
        do_xfer(32'h0000_0001, 1'b1, 3'd0, 32'h0, 0, 1'b0, waits);
        chk("byte1_pstrb", obs_pstrb, 4'b0010);
        do_xfer(32'h0000_0003, 1'b1, 3'd1, 32'h0, 0, 1'b0, waits);
        chk("half3_pstrb", obs_pstrb, 4'b1100);
        chk("hrdata_hold_wr", bus.hrdata, 32'h12345678);

        // pslverr on slave 3
        do_xfer(32'h0000_3000, 1'b0, 3'd2, 32'h0, 0, 1'b1, waits);
        chk("slverr_waits",     waits,      3);
        chk("slverr_err1_cnt",  hresp_cnt,  1);
        chk("slverr_err1_psel", err_psel,   4'h0);
        chk("slverr_err2_hresp", bus.hresp, 1'b1);
        chk("slverr_err2_psel", bus.psel,   4'h0);
        chk("hrdata_hold_err",  bus.hrdata, 32'h12345678);
        tick();
        chk("slverr_after_hresp", bus.hresp, 1'b0);

        // Doubleword on a 32-bit bus
        do_xfer(32'h0000_1000, 1'b1, 3'd3, 32'h0, 0, 1'b0, waits);
        chk("size3_waits", waits,     1);
        chk("size3_hresp", bus.hresp, 1'b1);
        chk("size3_psel",  any_psel,  4'h0);
        tick();
        chk("size3_after_hresp", bus.hresp, 1'b0);

        // Unmapped region on the 3-slave instance
        bus3.hsel = 1'b1; bus3.haddr = 32'h0000_3000; bus3.htrans = HTRANS_NONSEQ;
        bus3.hwrite = 1'b0; bus3.hsize = 3'd2;
        tick();
        bus3.hsel = 1'b0; bus3.htrans = HTRANS_IDLE;
        chk("unmap_err1_hresp", bus3.hresp,     1'b1);
        chk("unmap_err1_rdy",   bus3.hreadyout, 1'b0);
        chk("unmap_err1_psel",  bus3.psel,      3'b000);
        tick();
        chk("unmap_err2_hresp", bus3.hresp,     1'b1);
        chk("unmap_err2_rdy",   bus3.hreadyout, 1'b1);
        chk("unmap_err2_psel",  bus3.psel,      3'b000);
        tick();
        chk("unmap_after_hresp", bus3.hresp,    1'b0);

        // Back-to-back read then write presented in the completion cycle
        do_xfer(32'h0000_0000, 1'b0, 3'd2, 32'h0, 0, 1'b0, waits_r);
        c0 = cyc;
        do_xfer(32'h0000_3010, 1'b1, 3'd2, 32'h0BADC0DE, 0, 1'b0, waits);
        c1 = cyc;
        chk("b2b_rd_waits", waits_r,    2);
        chk("b2b_wr_waits", waits,      3);
        chk("b2b_cycles",   c1 - c0,    4);
        chk("b2b_wr_psel",  obs_psel,   4'b1000);
        chk("b2b_wr_pwdata", obs_pwdata, 32'h0BADC0DE);
        chk("b2b_hrdata",   bus.hrdata, 32'hCAFEF00D);
        tick();

`ifdef APB_TIMEOUT_EN
        do_xfer(32'h0000_0000, 1'b0, 3'd2, 32'h0, 100000, 1'b0, waits);
        chk("tmo_waits", waits,     258);
        chk("tmo_hresp", bus.hresp, 1'b1);
        chk("tmo_psel",  bus.psel,  4'h0);
        tick();
`endif

        // Reset asserted while the read sits in ACCESS
        bus.pready = 4'h0;
        bus.hsel = 1'b1; bus.haddr = 32'h0000_1000; bus.htrans = HTRANS_NONSEQ;
        bus.hwrite = 1'b0; bus.hsize = 3'd2;
        tick();
        bus_idle();
        tick();
        chk("rstmid_penable", bus.penable, 1'b1);
        hreset = 1'b1;
        tick();
        chk("rstmid_psel",      bus.psel,      4'h0);
        chk("rstmid_penable0",  bus.penable,   1'b0);
        chk("rstmid_hreadyout", bus.hreadyout, 1'b1);
        chk("rstmid_hrdata",    bus.hrdata,    32'h0);
        hreset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
